// File: rtl/bias_loader.sv
// bias_loader: assembles a byte stream into a shadow bias vector and swaps it
// into the live bias_out only on an explicit commit, so the bias stage never
// sees a partially loaded vector. Byte k lands in lane SIZE-1-k (first byte
// in the MSB lane). Every output is registered.
// Optional build macro BIAS_LOADER_CHECKSUM_EN: after the SIZE data bytes one
// extra checksum byte (sum of the data bytes modulo 256) is expected; a bad
// checksum discards the shadow and pulses csum_err for one cycle.
module bias_loader #(
  parameter int SIZE  = 4,
  parameter int CNT_W = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          in_data,
  input  logic                clear,
  input  logic                commit,
  output logic [8*SIZE-1:0]   bias_out,
  output logic                bias_valid,
  output logic                bias_loaded,
`ifdef BIAS_LOADER_CHECKSUM_EN
  output logic                csum_err,
`endif
  output logic                shadow_full
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    FULL  = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(SIZE - 1);

  state_t              state, state_nx;
  logic [CNT_W-1:0]    count, count_nx;
  logic [8*SIZE-1:0]   shadow, shadow_nx;
  logic [8*SIZE-1:0]   bias_nx;
  logic                bias_valid_nx;
  logic                bias_loaded_nx;
  logic                shadow_full_nx;
  logic                in_ready_nx;
  logic                xfer;
`ifdef BIAS_LOADER_CHECKSUM_EN
  logic [7:0]          csum, csum_nx;
  logic                csum_err_nx;
`endif

  assign xfer = in_valid && in_ready;

  // Register all state and outputs; asynchronous reset returns to an empty FILL.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= FILL;
      count       <= '0;
      shadow      <= '0;
      bias_out    <= '0;
      bias_valid  <= 1'b0;
      bias_loaded <= 1'b0;
      shadow_full <= 1'b0;
      in_ready    <= 1'b0;
`ifdef BIAS_LOADER_CHECKSUM_EN
      csum        <= '0;
      csum_err    <= 1'b0;
`endif
    end else begin
      state       <= state_nx;
      count       <= count_nx;
      shadow      <= shadow_nx;
      bias_out    <= bias_nx;
      bias_valid  <= bias_valid_nx;
      bias_loaded <= bias_loaded_nx;
      shadow_full <= shadow_full_nx;
      in_ready    <= in_ready_nx;
`ifdef BIAS_LOADER_CHECKSUM_EN
      csum        <= csum_nx;
      csum_err    <= csum_err_nx;
`endif
    end
  end

  // Next-state and next-output logic; clear overrides commit and any byte transfer.
  always_comb begin
    state_nx       = state;
    count_nx       = count;
    shadow_nx      = shadow;
    bias_nx        = bias_out;
    bias_valid_nx  = bias_valid;
    bias_loaded_nx = 1'b0;
    shadow_full_nx = shadow_full;
    in_ready_nx    = in_ready;
`ifdef BIAS_LOADER_CHECKSUM_EN
    csum_nx        = csum;
    csum_err_nx    = 1'b0;
`endif

    if (clear) begin
      state_nx       = FILL;
      count_nx       = '0;
      shadow_full_nx = 1'b0;
      in_ready_nx    = 1'b1;
    end else begin
      case (state)
        FILL: begin
          // in_ready rises here on the first edge after reset release
          in_ready_nx = 1'b1;
          if (xfer) begin
            for (int i = 0; i < SIZE; i++) begin
              if (count == CNT_W'(SIZE - 1 - i)) begin
                shadow_nx[8*i +: 8] = in_data;
              end
            end
`ifdef BIAS_LOADER_CHECKSUM_EN
            // running checksum restarts with the first byte of every load
            csum_nx = (count == '0) ? in_data : csum + in_data;
`endif
            if (count == LAST_LANE) begin
              count_nx = '0;
`ifdef BIAS_LOADER_CHECKSUM_EN
              state_nx = CHECK;
`else
              state_nx       = FULL;
              shadow_full_nx = 1'b1;
              in_ready_nx    = 1'b0;
`endif
            end else begin
              count_nx = count + CNT_W'(1);
            end
          end
        end

        FULL: begin
          in_ready_nx = 1'b0;
          if (commit) begin
            bias_nx        = shadow;
            bias_valid_nx  = 1'b1;
            bias_loaded_nx = 1'b1;
            shadow_full_nx = 1'b0;
            in_ready_nx    = 1'b1;
            state_nx       = FILL;
          end
        end

`ifdef BIAS_LOADER_CHECKSUM_EN
        CHECK: begin
          in_ready_nx = 1'b1;
          if (xfer) begin
            if (in_data == csum) begin
              state_nx       = FULL;
              shadow_full_nx = 1'b1;
              in_ready_nx    = 1'b0;
            end else begin
              // bad checksum: drop the load and start over
              state_nx    = FILL;
              count_nx    = '0;
              csum_err_nx = 1'b1;
            end
          end
        end
`endif

        default: begin
          state_nx       = FILL;
          count_nx       = '0;
          shadow_full_nx = 1'b0;
          in_ready_nx    = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/bias_loader.md
Name: bias_loader

Overview:
- Writer-side counterpart of the bias lane adder: it produces the packed SIZE-lane, 8-bit-per-lane `b` vector that the bias stage consumes.
- Accepts a byte stream over a valid/ready handshake and assembles it into a shadow register.
- Swaps the shadow register into the live bias vector only on an explicit commit, so the bias stage never sees a partially loaded vector.
- Sits between the weight/bias memory streamer and the bias stage of each layer.

Parameters:
- SIZE, 4, number of 8-bit lanes; bias_out width is 8*SIZE.
- CNT_W, 8, width of the lane counter; must satisfy 2**CNT_W > SIZE.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  loader accepts a byte this cycle.
- in_data  in  8  bias byte.
- clear  in  1  synchronous abort; discards the partial shadow load.
- commit  in  1  request to transfer a full shadow into bias_out.
- bias_out  out  8*SIZE  live bias vector; lane SIZE-1 occupies the MSBs.
- bias_valid  out  1  bias_out holds at least one committed vector.
- bias_loaded  out  1  one-cycle pulse after each successful commit.
- shadow_full  out  1  shadow complete, awaiting commit.

Behaviour:
- Reset (reset=0, asynchronous): all outputs are registered and take these values: bias_out=0, bias_valid=0, bias_loaded=0, shadow_full=0, in_ready=0. State=FILL, lane count=0, shadow=0.
- After reset deasserts, in_ready rises at the first rising edge.

FSM, states FILL and FULL:
- Byte transfer: a byte transfers at a rising edge where in_valid && in_ready.
- Byte order: byte k (k=0..SIZE-1) is written to lane SIZE-1-k, i.e. bits [8*(SIZE-k)-1 -: 8]. The first byte lands in the MSB lane.
- FILL: each transfer increments the count.
- On the transfer of byte SIZE-1: count returns to 0, state goes to FULL, shadow_full=1 and in_ready=0, both visible after that same edge.
- FULL: in_ready=0 and in_valid is ignored.
- commit sampled high in FULL:
  - bias_out <= shadow at that edge.
  - bias_valid <= 1; it is sticky until reset.
  - bias_loaded is high for exactly the following cycle.
  - shadow_full <= 0, in_ready <= 1, state goes to FILL.
- commit in FILL is ignored: no change to bias_out and no pulse.
- clear:
  - In either state, clear forces state=FILL, count=0, shadow_full=0, in_ready=1 at the next edge.
  - bias_out and bias_valid are untouched.
  - clear has priority over a simultaneous commit and over a simultaneous byte transfer; that byte is dropped.
- Back-to-back operation: a new fill may begin the cycle after commit, since in_ready is already 1. bias_out is stable throughout the new fill.
- Data handling: no arithmetic is performed on data; bytes are stored verbatim as unsigned.
- Reset mid-fill: all partial state is lost and the loader returns to the reset values.

Optional Feature:
- Macro: BIAS_LOADER_CHECKSUM_EN.
- Enabled:
  - Adds a port `csum_err` (out, 1).
  - After byte SIZE-1 the FSM enters state CHECK with in_ready=1 and accepts one extra byte.
  - If that byte equals the sum of the SIZE data bytes modulo 256: go to FULL.
  - Otherwise: discard the shadow, pulse csum_err for one cycle, return to FILL with count=0.
  - clear aborts CHECK the same way it aborts FILL.
  - csum_err resets to 0.
- Disabled: there is no CHECK state and no csum_err port; behaviour is exactly as above.

Test Plan:
- Reset release, then bytes 1,2,3,4 with in_valid held, then commit one cycle later -> shadow_full=1 after the 4th transfer; after commit, bias_out=32'h01020304, bias_loaded high for 1 cycle, bias_valid=1.
- Committed 01020304, then load 31,28,53,94 with in_valid toggling every other cycle -> bias_out stays 32'h01020304 until commit, then becomes 32'h1F1C355E; in_ready low in FULL; a 5th in_valid byte is not accepted.
- Load 128,128,200 then assert clear together with in_valid on byte 255 -> byte dropped, count=0; a subsequent load of 127,128,200,255 plus commit gives 32'h7F80C8FF.
- commit asserted in FILL with 2 bytes loaded -> no bias_loaded pulse, bias_out unchanged; in FULL, commit and clear in the same cycle -> clear wins, bias_out unchanged, state FILL.
- Assert reset asynchronously mid-fill (between clock edges) after 3 bytes -> outputs go to reset values immediately; after release, a full 4-byte load is required before shadow_full=1.
- With BIAS_LOADER_CHECKSUM_EN:
  - Bytes 1,2,3,4 plus checksum 10 -> FULL; commit gives 32'h01020304.
  - Bytes 1,2,3,4 plus checksum 11 -> csum_err pulses once, state returns to FILL, bias_out unchanged.
  - Bytes 200,100,0,0 plus checksum 44 -> accepted (wraps modulo 256).
